// File: rtl/vga_frame_scanner.sv
// rtl/vga_frame_scanner.sv - VGA scan-out engine with pixel divider, framebuffer fetch and frame-aligned start/stop
module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIX_FMT  = 0,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              fb_rd_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [7:0]        fb_data_i,
    output logic              vgaclk_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              sync_b_o,
    output logic              blank_b_o,
    output logic [7:0]        r_o,
    output logic [7:0]        g_o,
    output logic [7:0]        b_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DCNT_MAX = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic tick, active, hs_n, vs_n, frame_end;
    logic [7:0] pix_r, pix_g, pix_b;

    // Stage 1 holds the timing of the tick whose pixel is in flight from memory
    logic tick_p_q, act_p_q, hs_p_q, vs_p_q, last_p_q;

    logic       vgaclk_q, hsync_q, vsync_q, blank_b_q, frame_done_q;
    logic [7:0] r_q, g_q, b_q;

    always_comb begin
        tick      = (state_q != S_IDLE) && (dcnt_q == DCNT_MAX);
        active    = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
        hs_n      = !((int'(hcnt_q) >= H_ACTIVE + H_FP) && (int'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC));
        vs_n      = !((int'(vcnt_q) >= V_ACTIVE + V_FP) && (int'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC));
        frame_end = tick && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    end

    always_comb begin
        if (PIX_FMT == 1) begin
            pix_r = {fb_data_i[7:5], fb_data_i[7:5], fb_data_i[7:6]};
            pix_g = {fb_data_i[4:2], fb_data_i[4:2], fb_data_i[4:3]};
            pix_b = {4{fb_data_i[1:0]}};
        end else begin
            pix_r = fb_data_i;
            pix_g = fb_data_i;
            pix_b = fb_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            // A stop request landing on the frame-end tick ends scanning right there
            S_RUN:   if (!start_i) state_d = frame_end ? S_IDLE : S_DRAIN;
            S_DRAIN: begin
                if (start_i)        state_d = S_RUN;
                else if (frame_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE) begin
            dcnt_d = '0;
            hcnt_d = '0;
            vcnt_d = '0;
            addr_d = '0;
        end else begin
            dcnt_d = tick ? '0 : dcnt_q + DW'(1);
            if (tick) begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            if (frame_end)           addr_d = '0;
            else if (tick && active) addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            addr_q       <= '0;
            tick_p_q     <= 1'b0;
            act_p_q      <= 1'b0;
            hs_p_q       <= 1'b1;
            vs_p_q       <= 1'b1;
            last_p_q     <= 1'b0;
            vgaclk_q     <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            blank_b_q    <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            addr_q   <= addr_d;
            tick_p_q <= tick;
            vgaclk_q <= int'(dcnt_q) >= CLK_DIV / 2;
            if (tick) begin
                act_p_q  <= active;
                hs_p_q   <= hs_n;
                vs_p_q   <= vs_n;
                last_p_q <= frame_end;
            end
            // Video outputs change only when a fetched pixel lands, keeping colour and sync aligned
            if (tick_p_q) begin
                blank_b_q    <= act_p_q;
                hsync_q      <= hs_p_q;
                vsync_q      <= vs_p_q;
                r_q          <= act_p_q ? pix_r : 8'h00;
                g_q          <= act_p_q ? pix_g : 8'h00;
                b_q          <= act_p_q ? pix_b : 8'h00;
                frame_done_q <= last_p_q;
            end else begin
                frame_done_q <= 1'b0;
                if (state_q == S_IDLE) begin
                    hsync_q   <= 1'b1;
                    vsync_q   <= 1'b1;
                    blank_b_q <= 1'b0;
                    r_q       <= '0;
                    g_q       <= '0;
                    b_q       <= '0;
                end
            end
        end
    end

    assign fb_rd_o      = tick && active;
    assign fb_addr_o    = addr_q;
    assign vgaclk_o     = vgaclk_q;
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign sync_b_o     = 1'b0;
    assign blank_b_o    = blank_b_q;
    assign r_o          = r_q;
    assign g_o          = g_q;
    assign b_o          = b_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = state_q != S_IDLE;

endmodule
